map_ss_engine: RTL and testbench
================================

Name: map_ss_engine

Overview:
- Save-state initiator: the system-side counterpart of the per-mapper save-state responder logic behind the mapper hub.
- On command it walks the mapper save-state register space byte by byte.
  - Save: reads each mapper register and writes it to save-state memory.
  - Restore: reads memory and writes the byte back to the mapper.
- Sits between the menu/CPU command interface and the hub's ss_ctrl input and map_out save-state readback.

Parameters:
SS_LEN, 256, number of save-state bytes walked (1..256)
ADDR_W, 8, width of ss_addr and mem_addr
RD_LAT, 2, cycles from ss_addr presentation to valid ss_rdat (1..4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cmd_start  in  1  one-cycle start pulse; ignored while busy
cmd_dir  in  1  0 = save (mapper->mem), 1 = restore (mem->mapper); sampled with cmd_start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the walk completes
ss_act  out  1  save-state window active toward mappers
ss_we  out  1  one-cycle mapper register write strobe
ss_addr  out  ADDR_W  mapper register index
ss_wdat  out  8  restore data to mapper
ss_rdat  in  8  mapper readback data
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  ADDR_W  memory byte address (equals ss_addr)
mem_wdat  out  8  save data to memory
mem_rdat  in  8  memory read data; valid in the mem_ack cycle
mem_ack  in  1  one-cycle completion; may arrive in the cycle after req or any later cycle
ss_crc  out  8  checksum of transferred bytes (see Optional Feature)

Behaviour:
- Reset (async, rst high): state IDLE.
  - All outputs 0: busy, done, ss_act, ss_we, mem_req, mem_we, ss_addr, mem_addr, ss_wdat, mem_wdat, ss_crc.
  - Internal index and latency counter cleared.
- FSM states: IDLE, MAP_RD, MAP_WAIT, MEM_WR, MEM_RD, MAP_WR, NEXT, FIN.
- IDLE:
  - cmd_start=1 -> busy=1, ss_act=1, index=0, latch cmd_dir.
  - Next state MAP_RD (save) or MEM_RD (restore).
- Save path:
  - MAP_RD: drive ss_addr=index, load latency counter = RD_LAT-1 -> MAP_WAIT.
  - MAP_WAIT: decrement each cycle; at 0, capture ss_rdat into mem_wdat -> MEM_WR.
  - Net: ss_rdat is sampled exactly RD_LAT cycles after MAP_RD.
  - MEM_WR: mem_req=1, mem_we=1, mem_addr=index; hold all until mem_ack -> drop mem_req in the same edge -> NEXT.
- Restore path:
  - MEM_RD: mem_req=1, mem_we=0; on mem_ack capture mem_rdat into ss_wdat -> MAP_WR.
  - MAP_WR: ss_addr=index, ss_we=1 for exactly one cycle -> NEXT.
- NEXT:
  - index == SS_LEN-1 -> FIN.
  - Otherwise index+1, back to MAP_RD or MEM_RD.
  - Index never wraps: the last address used is SS_LEN-1; SS_LEN=256 with ADDR_W=8 ends at 0xFF.
- FIN: done=1 for one cycle, busy=0, ss_act=0 -> IDLE.
  - ss_addr and mem_addr hold their last value until the next start.
- ss_act stays high for the whole walk, so mappers freeze normal register writes.
- cmd_start while busy: ignored, no queueing.
- cmd_start in the FIN cycle: ignored. Accepted from IDLE only, so the earliest restart is the cycle after done.
- mem_ack outside MEM_WR/MEM_RD: ignored.
- Reset mid-walk:
  - Immediate abort, all outputs to reset values, no done pulse.
  - A partial memory image is permitted.
- Throughput per byte:
  - Save: RD_LAT + 1 + ack wait + 1 cycles.
  - Restore: ack wait + 2 cycles.

Optional Feature:
- Macro: MAP_SS_CRC_EN.
- Defined:
  - ss_crc is a CRC-8, poly 0x07, init 0x00, MSB-first.
  - It covers every byte transferred: save = captured ss_rdat, restore = captured mem_rdat.
  - Updated in the capture cycle; cleared on an accepted cmd_start.
  - Value is stable after done until the next start.
- Not defined: ss_crc is tied to 0 and no CRC logic is synthesized.

Test Plan:
- Save, SS_LEN=4, RD_LAT=2, mapper model returns addr^0xA5, mem_ack 1 cycle after req:
  - mem sees writes A5,A4,A7,A6 at addresses 0..3.
  - done pulses once; busy high the whole walk; ss_we never asserted.
- Restore, SS_LEN=4, mem holds 11,22,33,44, mem_ack delayed 3 cycles:
  - four single-cycle ss_we strobes with ss_addr 0..3 and ss_wdat 11,22,33,44.
  - mem_req held steady through each stall.
- cmd_start pulsed mid-walk and again in the FIN cycle:
  - no restart, no second done.
  - a start the cycle after done is accepted.
- rst asserted during MEM_WR at index 2:
  - all outputs 0 asynchronously, no done.
  - a following start begins at ss_addr 0.
- SS_LEN=256 save: last mem_addr is 0xFF, exactly 256 mem writes, no wrap to 0.
- With MAP_SS_CRC_EN, save of the single byte 0x01 (SS_LEN=1): ss_crc=0x07 after done; without the macro, ss_crc=0x00.

Source files
------------

// File: rtl/map_ss_engine_if.sv
// map_ss_engine_if: command, mapper save-state and memory signals of the
// save-state initiator. The engine uses the master modport; the menu/CPU,
// mapper hub and save-state memory side uses the slave modport.
interface map_ss_engine_if #(
  parameter int ADDR_W = 8
);
  // Command side
  logic              cmd_start;
  logic              cmd_dir;
  logic              busy;
  logic              done;
  // Mapper save-state side
  logic              ss_act;
  logic              ss_we;
  logic [ADDR_W-1:0] ss_addr;
  logic [7:0]        ss_wdat;
  logic [7:0]        ss_rdat;
  // Save-state memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdat;
  logic [7:0]        mem_rdat;
  logic              mem_ack;
  // Checksum of the transferred image
  logic [7:0]        ss_crc;

  modport master (
    input  cmd_start, cmd_dir, ss_rdat, mem_rdat, mem_ack,
    output busy, done, ss_act, ss_we, ss_addr, ss_wdat,
           mem_req, mem_we, mem_addr, mem_wdat, ss_crc
  );

  modport slave (
    output cmd_start, cmd_dir, ss_rdat, mem_rdat, mem_ack,
    input  busy, done, ss_act, ss_we, ss_addr, ss_wdat,
           mem_req, mem_we, mem_addr, mem_wdat, ss_crc
  );
endinterface

// File: rtl/map_ss_engine.sv
// map_ss_engine: save-state initiator. On a start command it walks the
// mapper save-state register space byte by byte, either copying mapper
// registers into save-state memory (save) or memory back into the mappers
// (restore). ss_act is held for the whole walk so mappers freeze their
// normal register writes.
//
// Optional feature: define MAP_SS_CRC_EN to compute a CRC-8 (poly 0x07,
// init 0x00, MSB-first) over every transferred byte on ss_crc. Without the
// macro ss_crc is tied to zero and no CRC logic exists.
module map_ss_engine #(
  parameter int SS_LEN = 256,  // bytes walked, 1..256
  parameter int ADDR_W = 8,    // width of ss_addr / mem_addr
  parameter int RD_LAT = 2     // ss_addr to valid ss_rdat, 1..4 cycles
) (
  input logic            clk,
  input logic            rst,
  map_ss_engine_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    MAP_RD,
    MAP_WAIT,
    MEM_WR,
    MEM_RD,
    MAP_WR,
    NEXT,
    FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SS_LEN - 1);
  localparam logic [1:0]        LAT_LOAD = 2'(RD_LAT - 1);

  state_t            state;
  logic              dir;      // 0 = save, 1 = restore, latched at start
  logic [ADDR_W-1:0] index;
  logic [1:0]        lat_cnt;

  logic              busy_q;
  logic              done_q;
  logic              ss_act_q;
  logic              ss_we_q;
  logic [ADDR_W-1:0] ss_addr_q;
  logic [7:0]        ss_wdat_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdat_q;

  // Walk sequencer: every output is a register updated on the transition
  // into the state that needs it, so outputs are glitch-free.
  // NOTE: the asynchronous reset clears every output register as well as the
  // state, so an aborted walk leaves nothing asserted toward mappers or memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= 1'b0;
      index      <= '0;
      lat_cnt    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ss_act_q   <= 1'b0;
      ss_we_q    <= 1'b0;
      ss_addr_q  <= '0;
      ss_wdat_q  <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wdat_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout: every register here sees
      // the pre-edge values of the others, independent of statement order.
      case (state)
        IDLE: begin
          if (bus.cmd_start) begin
            busy_q     <= 1'b1;
            ss_act_q   <= 1'b1;
            dir        <= bus.cmd_dir;
            index      <= '0;
            ss_addr_q  <= '0;
            mem_addr_q <= '0;
            if (bus.cmd_dir) begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state     <= MEM_RD;
            end else begin
              state     <= MAP_RD;
            end
          end
        end

        // ss_addr is already presented; arm the read latency counter.
        MAP_RD: begin
          lat_cnt <= LAT_LOAD;
          state   <= MAP_WAIT;
        end

        // Capture the mapper byte once the read latency has elapsed and
        // raise the memory write request in the same edge.
        MAP_WAIT: begin
          if (lat_cnt == 2'd0) begin
            mem_wdat_q <= bus.ss_rdat;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            state      <= MEM_WR;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end

        // Request, direction, address and data held steady until the ack.
        MEM_WR: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state     <= NEXT;
          end
        end

        // Memory read: the data is valid in the ack cycle only.
        MEM_RD: begin
          if (bus.mem_ack) begin
            ss_wdat_q <= bus.mem_rdat;
            mem_req_q <= 1'b0;
            ss_we_q   <= 1'b1;
            state     <= MAP_WR;
          end
        end

        // The write strobe toward the mapper lasts exactly this one cycle.
        MAP_WR: begin
          ss_we_q <= 1'b0;
          state   <= NEXT;
        end

        // Stop on the last index instead of incrementing, so the index never
        // wraps even when SS_LEN fills the whole address space.
        NEXT: begin
          if (index == LAST_IDX) begin
            busy_q   <= 1'b0;
            ss_act_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= FIN;
          end else begin
            index      <= index + ADDR_W'(1);
            ss_addr_q  <= index + ADDR_W'(1);
            mem_addr_q <= index + ADDR_W'(1);
            if (dir) begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state     <= MEM_RD;
            end else begin
              state     <= MAP_RD;
            end
          end
        end

        // One-cycle done pulse; a start seen here is dropped.
        FIN: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ss_act   = ss_act_q;
  assign bus.ss_we    = ss_we_q;
  assign bus.ss_addr  = ss_addr_q;
  assign bus.ss_wdat  = ss_wdat_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdat = mem_wdat_q;

`ifdef MAP_SS_CRC_EN
  // One CRC-8 step over a whole byte, poly 0x07, MSB first.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  logic       cap_en;
  logic [7:0] cap_byte;
  logic [7:0] crc_q;

  // Select the byte being captured this cycle, whichever direction.
  // NOTE: both outputs get a default first so no path leaves them unassigned
  // and no latch is inferred.
  always_comb begin
    cap_en   = 1'b0;
    cap_byte = bus.ss_rdat;
    if (state == MAP_WAIT && lat_cnt == 2'd0) begin
      cap_en   = 1'b1;
      cap_byte = bus.ss_rdat;
    end else if (state == MEM_RD && bus.mem_ack) begin
      cap_en   = 1'b1;
      cap_byte = bus.mem_rdat;
    end
  end

  // Checksum accumulates per captured byte, restarts on an accepted start
  // and holds after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else if (state == IDLE && bus.cmd_start) begin
      crc_q <= 8'h00;
    end else if (cap_en) begin
      crc_q <= crc8_next(crc_q, cap_byte);
    end
  end

  assign bus.ss_crc = crc_q;
`else
  assign bus.ss_crc = 8'h00;
`endif

endmodule

// File: tb/tb_map_ss_engine.sv
// tb_map_ss_engine: directed test of the save-state initiator. Three
// instances cover a 4-byte walk (save, restore, ignored starts, reset abort),
// a full 256-byte save and a 1-byte save for the checksum.
module tb_map_ss_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  map_ss_engine_if #(.ADDR_W(8)) b4 ();
  map_ss_engine_if #(.ADDR_W(8)) b256 ();
  map_ss_engine_if #(.ADDR_W(8)) b1 ();

  map_ss_engine #(.SS_LEN(4), .ADDR_W(8), .RD_LAT(2)) u4 (
    .clk(clk), .rst(rst), .bus(b4.master));
  map_ss_engine #(.SS_LEN(256), .ADDR_W(8), .RD_LAT(2)) u256 (
    .clk(clk), .rst(rst), .bus(b256.master));
  map_ss_engine #(.SS_LEN(1), .ADDR_W(8), .RD_LAT(2)) u1 (
    .clk(clk), .rst(rst), .bus(b1.master));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

`ifdef MAP_SS_CRC_EN
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int k = 0; k < 8; k++) r = r[7] ? 8'((r << 1) ^ 8'h07) : 8'(r << 1);
    return r;
  endfunction
`endif

  // ---------------- environment of the 4-byte instance ----------------
  // Mapper returns addr^A5 two cycles after the address; memory acks
  // dly4 cycles after the request cycle and returns 11,22,33,44 on reads.
  int         dly4 = 1, cnt4 = 0, nw4 = 0, ns4 = 0, ndone4 = 0;
  int         stall4 = 0, dbl4 = 0;
  logic       we_prev4 = 1'b0;
  logic [7:0] p4 = 8'h00;
  logic [7:0] wa4 [64];
  logic [7:0] wd4 [64];
  logic [7:0] sa4 [64];
  logic [7:0] sd4 [64];

  always @(negedge clk) begin
    if (rst) begin
      b4.mem_ack = 1'b0; b4.mem_rdat = 8'h00; b4.ss_rdat = 8'h00;
      p4 = 8'h00; cnt4 = 0; we_prev4 = 1'b0;
    end else begin
      b4.ss_rdat = p4;
      p4 = b4.ss_addr ^ 8'hA5;
      if (b4.mem_ack) begin
        b4.mem_ack = 1'b0;
      end else if (b4.mem_req) begin
        if (cnt4 == dly4) begin
          b4.mem_ack  = 1'b1;
          b4.mem_rdat = 8'(8'h11 * (b4.mem_addr + 8'd1));
          cnt4 = 0;
          if (b4.mem_we) begin
            wa4[nw4] = b4.mem_addr; wd4[nw4] = b4.mem_wdat; nw4++;
          end
        end else begin
          cnt4++;
        end
      end else if (cnt4 != 0) begin
        stall4++;
      end
      if (b4.ss_we) begin
        sa4[ns4] = b4.ss_addr; sd4[ns4] = b4.ss_wdat; ns4++;
        if (we_prev4) dbl4++;
      end
      we_prev4 = b4.ss_we;
      if (b4.done) ndone4++;
    end
  end

  // ---------------- environment of the 256-byte instance ----------------
  int         nw256 = 0, seq256 = 0;
  logic       pend256 = 1'b0;
  logic [7:0] p256 = 8'h00, last_a256 = 8'h00, last_d256 = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      b256.mem_ack = 1'b0; b256.mem_rdat = 8'h00; b256.ss_rdat = 8'h00;
      p256 = 8'h00; pend256 = 1'b0;
    end else begin
      b256.ss_rdat = p256;
      p256 = b256.ss_addr ^ 8'h5A;
      if (b256.mem_ack) begin
        b256.mem_ack = 1'b0;
      end else if (b256.mem_req) begin
        if (pend256) begin
          b256.mem_ack = 1'b1; pend256 = 1'b0;
          if (b256.mem_we) begin
            if (b256.mem_addr != 8'(nw256)) seq256++;
            last_a256 = b256.mem_addr; last_d256 = b256.mem_wdat; nw256++;
          end
        end else begin
          pend256 = 1'b1;
        end
      end
    end
  end

  // ---------------- environment of the 1-byte instance ----------------
  int         nw1 = 0;
  logic       pend1 = 1'b0;
  logic [7:0] p1 = 8'h00, d1 = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      b1.mem_ack = 1'b0; b1.mem_rdat = 8'h00; b1.ss_rdat = 8'h00;
      p1 = 8'h00; pend1 = 1'b0;
    end else begin
      b1.ss_rdat = p1;
      p1 = b1.ss_addr ^ 8'h01;
      if (b1.mem_ack) begin
        b1.mem_ack = 1'b0;
      end else if (b1.mem_req) begin
        if (pend1) begin
          b1.mem_ack = 1'b1; pend1 = 1'b0;
          if (b1.mem_we) begin d1 = b1.mem_wdat; nw1++; end
        end else begin
          pend1 = 1'b1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic start4(input logic d);
    @(negedge clk);
    b4.cmd_start = 1'b1; b4.cmd_dir = d;
    @(negedge clk);
    b4.cmd_start = 1'b0; b4.cmd_dir = 1'b0;
  endtask

  // Returns at the negedge of the done cycle; busy must stay high before it.
  task automatic wait_done4(input string tag);
    int bad = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (b4.done) begin seen = 1'b1; break; end
      if (!b4.busy) bad++;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_busy_held"}, bad, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, d0;
    bit found;
    logic [7:0] exp_crc;

    b4.cmd_start = 1'b0;   b4.cmd_dir = 1'b0;
    b256.cmd_start = 1'b0; b256.cmd_dir = 1'b0;
    b1.cmd_start = 1'b0;   b1.cmd_dir = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(b4.busy), 0);
    check("rst_done", 32'(b4.done), 0);
    check("rst_ss_act", 32'(b4.ss_act), 0);
    check("rst_ss_we", 32'(b4.ss_we), 0);
    check("rst_mem_req_we", {b4.mem_req, b4.mem_we}, 0);
    check("rst_addrs", {b4.ss_addr, b4.mem_addr}, 0);
    check("rst_data", {b4.ss_wdat, b4.mem_wdat, b4.ss_crc}, 0);
    rst = 1'b0;

    // Save of 4 bytes, ack one cycle after request
    dly4 = 1; base = nw4; d0 = ndone4;
    start4(1'b0);
    wait_done4("save4");
    @(negedge clk);
    check("save4_nwrites", nw4 - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("save4_addr%0d", i), 32'(wa4[base+i]), i);
    end
    check("save4_data0", 32'(wd4[base+0]), 32'h A5);
    check("save4_data1", 32'(wd4[base+1]), 32'h A4);
    check("save4_data2", 32'(wd4[base+2]), 32'h A7);
    check("save4_data3", 32'(wd4[base+3]), 32'h A6);
    check("save4_one_done", ndone4 - d0, 1);
    check("save4_no_ss_we", ns4, 0);
    check("save4_idle", {b4.busy, b4.ss_act, b4.done}, 0);
    check("save4_addr_hold", {b4.ss_addr, b4.mem_addr}, 32'h 0303);
    exp_crc = 8'h00;
`ifdef MAP_SS_CRC_EN
    for (int i = 0; i < 4; i++) exp_crc = crc8(exp_crc, 8'(i) ^ 8'hA5);
`endif
    check("save4_crc", 32'(b4.ss_crc), 32'(exp_crc));

    // Restore of 4 bytes, ack three cycles after request
    dly4 = 3; base = nw4; d0 = ndone4;
    start4(1'b1);
    wait_done4("rest4");
    @(negedge clk);
    check("rest4_nstrobes", ns4, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rest4_addr%0d", i), 32'(sa4[i]), i);
      check($sformatf("rest4_data%0d", i), 32'(sd4[i]), 32'(8'h11 * (i + 1)));
    end
    check("rest4_single_strobe", dbl4, 0);
    check("rest4_req_steady", stall4, 0);
    check("rest4_no_mem_write", nw4 - base, 0);
    check("rest4_one_done", ndone4 - d0, 1);
    exp_crc = 8'h00;
`ifdef MAP_SS_CRC_EN
    exp_crc = crc8(crc8(crc8(crc8(8'h00, 8'h11), 8'h22), 8'h33), 8'h44);
`endif
    check("rest4_crc", 32'(b4.ss_crc), 32'(exp_crc));

    // Start mid-walk (as restore) and in the FIN cycle: both ignored
    dly4 = 1; base = nw4; d0 = ndone4;
    start4(1'b0);
    repeat (4) @(negedge clk);
    b4.cmd_start = 1'b1; b4.cmd_dir = 1'b1;
    @(negedge clk);
    b4.cmd_start = 1'b0; b4.cmd_dir = 1'b0;
    wait_done4("mid");
    b4.cmd_start = 1'b1;
    @(negedge clk);
    b4.cmd_start = 1'b0;
    check("fin_start_ignored", 32'(b4.busy), 0);
    repeat (3) @(negedge clk);
    check("fin_still_idle", {b4.busy, b4.ss_act}, 0);
    check("mid_one_done", ndone4 - d0, 1);
    check("mid_kept_save", nw4 - base, 4);
    check("mid_save_data", 32'(wd4[base+3]), 32'h A6);

    // Start in the cycle after done is accepted; then reset in MEM_WR idx 2
    start4(1'b0);
    wait_done4("pre");
    dly4 = 3;
    start4(1'b0);
    check("restart_after_done", 32'(b4.busy), 1);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b4.mem_req && b4.mem_we && b4.mem_addr == 8'd2) begin
        found = 1'b1; break;
      end
    end
    check("abort_reached_idx2", 32'(found), 1);
    d0 = ndone4;
    #1 rst = 1'b1;
    #1;
    check("abort_ctrl", {b4.busy, b4.done, b4.ss_act, b4.ss_we, b4.mem_req, b4.mem_we}, 0);
    check("abort_addrs", {b4.ss_addr, b4.mem_addr}, 0);
    check("abort_data", {b4.ss_wdat, b4.mem_wdat, b4.ss_crc}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", ndone4 - d0, 0);
    check("abort_idle", 32'(b4.busy), 0);
    dly4 = 1; base = nw4;
    start4(1'b0);
    check("post_abort_addr0", 32'(b4.ss_addr), 0);
    wait_done4("post");
    check("post_nwrites", nw4 - base, 4);
    check("post_first_addr", 32'(wa4[base]), 0);
    check("post_last_addr", 32'(wa4[base+3]), 3);

    // Full 256-byte save: no wrap, ends at 0xFF
    @(negedge clk);
    b256.cmd_start = 1'b1;
    @(negedge clk);
    b256.cmd_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (b256.done) begin found = 1'b1; break; end
    end
    check("s256_done", 32'(found), 1);
    @(negedge clk);
    check("s256_nwrites", nw256, 256);
    check("s256_sequence", seq256, 0);
    check("s256_last_addr", 32'(last_a256), 32'h FF);
    check("s256_last_data", 32'(last_d256), 32'h A5);
    check("s256_mem_addr_hold", 32'(b256.mem_addr), 32'h FF);

    // Single-byte save of 0x01 for the checksum
    b1.cmd_start = 1'b1;
    @(negedge clk);
    b1.cmd_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b1.done) begin found = 1'b1; break; end
    end
    check("s1_done", 32'(found), 1);
    @(negedge clk);
    check("s1_nwrites", nw1, 1);
    check("s1_data", 32'(d1), 32'h 01);
`ifdef MAP_SS_CRC_EN
    check("s1_crc", 32'(b1.ss_crc), 32'h 07);
`else
    check("s1_crc", 32'(b1.ss_crc), 32'h 00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
